// File: rtl/pid_pwm_driver.sv
// PWM output stage for the PID loop: clamps the control word to the period,
// slew-limits duty once per period and drives complementary gates with dead time.
module pid_pwm_driver #(
    parameter int DT_W       = 8,
    parameter int MIN_PERIOD = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [15:0]     control_signal,
    input  logic [15:0]     period,
    input  logic [DT_W-1:0] dead_time,
    input  logic [15:0]     max_step,
    output logic            pwm_hi,
    output logic            pwm_lo,
    output logic [15:0]     duty,
    output logic            sat_flag,
    output logic            period_start
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

    localparam logic [15:0] MIN_P = 16'(MIN_PERIOD);

    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [15:0]     duty_q, duty_d;
    logic [15:0]     per_q, per_d;
    logic            sat_q, sat_d;
    logic [DT_W-1:0] dt_q, dt_d;
    logic            raw_q, raw_d;
    logic            hi_q, hi_d;
    logic            lo_q, lo_d;
    logic            ps_q, ps_d;

    logic               do_load;
    logic [15:0]        per_s;
    logic [15:0]        tgt_s;
    logic               sat_s;
    logic [15:0]        duty_s;
    logic signed [16:0] diff_s;
    logic signed [16:0] step_s;
    logic               run_d;
    logic               entering_run;

    // Sample path: clamp to the latched-to-be period, then slew toward target.
    always_comb begin
        per_s = (period < MIN_P) ? MIN_P : period;
        if (control_signal[15]) begin
            tgt_s = 16'd0;
            sat_s = 1'b1;
        end else if (control_signal > per_s) begin
            tgt_s = per_s;
            sat_s = 1'b1;
        end else begin
            tgt_s = control_signal;
            sat_s = 1'b0;
        end
        diff_s = $signed({1'b0, tgt_s}) - $signed({1'b0, duty_q});
        step_s = $signed({1'b0, max_step});
        if (max_step == 16'd0 || (diff_s <= step_s && diff_s >= -step_s)) begin
            duty_s = tgt_s;
        end else if (diff_s > 17'sd0) begin
            duty_s = duty_q + max_step;
        end else begin
            duty_s = duty_q - max_step;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        do_load = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (enable) state_d = LOAD;
            end
            LOAD: begin
                do_load = 1'b1;
                cnt_d   = 16'd0;
                state_d = RUN;
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end else if (cnt_q == per_q - 16'd1) begin
                    do_load = 1'b1;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase

        duty_d = do_load ? duty_s : duty_q;
        per_d  = do_load ? per_s  : per_q;
        sat_d  = do_load ? sat_s  : sat_q;
    end

    // Gate outputs are computed from next-state values so they line up with cnt.
    always_comb begin
        run_d        = (state_d == RUN);
        entering_run = run_d && (state_q != RUN);
        raw_d        = run_d && (cnt_d < duty_d);
        if (entering_run || (raw_d != raw_q)) begin
            dt_d = '0;
        end else if (dt_q == '1) begin
            dt_d = dt_q;
        end else begin
            dt_d = dt_q + DT_W'(1);
        end
        hi_d = raw_d && (dt_d >= dead_time);
        lo_d = !raw_d && run_d && (dt_d >= dead_time);
        ps_d = run_d && (cnt_d == 16'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            duty_q  <= 16'd0;
            per_q   <= MIN_P;
            sat_q   <= 1'b0;
            dt_q    <= '0;
            raw_q   <= 1'b0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
            ps_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            per_q   <= per_d;
            sat_q   <= sat_d;
            dt_q    <= dt_d;
            raw_q   <= raw_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ps_q    <= ps_d;
        end
    end

    assign pwm_hi       = hi_q;
    assign pwm_lo       = lo_q;
    assign duty         = duty_q;
    assign sat_flag     = sat_q;
    assign period_start = ps_q;

endmodule

// File: tb/tb_pid_pwm_driver.sv
// Self-checking bench for pid_pwm_driver: directed scenarios plus a randomized
// run checked against a period-level behavioural model.
module tb_pid_pwm_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] control_signal = 16'd0;
    logic [15:0] period = 16'd0;
    logic [7:0]  dead_time = 8'd0;
    logic [15:0] max_step = 16'd0;
    logic        pwm_hi, pwm_lo, sat_flag, period_start;
    logic [15:0] duty;

    int n_cmp = 0;
    int n_err = 0;

    pid_pwm_driver #(.DT_W(8), .MIN_PERIOD(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .control_signal(control_signal), .period(period),
        .dead_time(dead_time), .max_step(max_step),
        .pwm_hi(pwm_hi), .pwm_lo(pwm_lo), .duty(duty),
        .sat_flag(sat_flag), .period_start(period_start)
    );

    always #5 clk = ~clk;

    task automatic do_reset;
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // From IDLE: one cycle in LOAD, then the first RUN cycle (cnt 0) is observed.
    task automatic start_run;
        enable = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        int ps_cnt = 0;
        int gate_cnt = 0;
        enable = 1'b0;
        control_signal = 16'd40; period = 16'd10;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({pwm_hi, pwm_lo, sat_flag, period_start} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {pwm_hi, pwm_lo, sat_flag, period_start}); end
        n_cmp++; if (duty !== 16'd0) begin n_err++; $display("FAIL reset_duty: got %0d want 0", duty); end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (period_start) ps_cnt++;
            if (pwm_hi || pwm_lo) gate_cnt++;
        end
        n_cmp++; if (ps_cnt !== 0) begin n_err++; $display("FAIL idle_period_start: got %0d pulses want 0", ps_cnt); end
        n_cmp++; if (gate_cnt !== 0) begin n_err++; $display("FAIL idle_gates: got %0d active cycles want 0", gate_cnt); end
        n_cmp++; if (duty !== 16'd0 || sat_flag !== 1'b0) begin n_err++; $display("FAIL idle_duty_sat: got %0d/%b want 0/0", duty, sat_flag); end
    endtask

    task automatic test_basic;
        do_reset;
        period = 16'd100; control_signal = 16'd25; max_step = 16'd0; dead_time = 8'd0;
        start_run;
        for (int k = 0; k < 3; k++) begin
            int hc = 0, lc = 0, pc = 0, both = 0;
            n_cmp++; if (duty !== 16'd25) begin n_err++; $display("FAIL basic_duty p%0d: got %0d want 25", k, duty); end
            n_cmp++; if (period_start !== 1'b1) begin n_err++; $display("FAIL basic_ps_first p%0d: got %b want 1", k, period_start); end
            for (int c = 0; c < 100; c++) begin
                hc += int'(pwm_hi); lc += int'(pwm_lo); pc += int'(period_start);
                if (pwm_hi && pwm_lo) both++;
                @(negedge clk);
            end
            n_cmp++; if (hc !== 25) begin n_err++; $display("FAIL basic_hi_cycles p%0d: got %0d want 25", k, hc); end
            n_cmp++; if (lc !== 75) begin n_err++; $display("FAIL basic_lo_cycles p%0d: got %0d want 75", k, lc); end
            n_cmp++; if (pc !== 1) begin n_err++; $display("FAIL basic_ps_count p%0d: got %0d want 1", k, pc); end
            n_cmp++; if (both !== 0) begin n_err++; $display("FAIL basic_overlap p%0d: got %0d want 0", k, both); end
        end
        enable = 1'b0;
    endtask

    task automatic test_clamp;
        do_reset;
        period = 16'd100; control_signal = 16'hFFFB; max_step = 16'd0; dead_time = 8'd0;
        start_run;
        for (int k = 0; k < 2; k++) begin
            int hc = 0, lc = 0;
            n_cmp++; if (duty !== (k == 0 ? 16'd0 : 16'd100)) begin n_err++; $display("FAIL clamp_duty p%0d: got %0d want %0d", k, duty, (k == 0 ? 0 : 100)); end
            n_cmp++; if (sat_flag !== 1'b1) begin n_err++; $display("FAIL clamp_sat p%0d: got %b want 1", k, sat_flag); end
            if (k == 0) control_signal = 16'd300;
            for (int c = 0; c < 100; c++) begin
                hc += int'(pwm_hi); lc += int'(pwm_lo);
                @(negedge clk);
            end
            n_cmp++; if (hc !== (k == 0 ? 0 : 100)) begin n_err++; $display("FAIL clamp_hi_cycles p%0d: got %0d want %0d", k, hc, (k == 0 ? 0 : 100)); end
            n_cmp++; if (lc !== (k == 0 ? 100 : 0)) begin n_err++; $display("FAIL clamp_lo_cycles p%0d: got %0d want %0d", k, lc, (k == 0 ? 100 : 0)); end
        end
        enable = 1'b0;
    endtask

    task automatic test_slew;
        int exp_d[8] = '{50, 100, 150, 180, 130, 80, 30, 0};
        do_reset;
        period = 16'd1000; control_signal = 16'd180; max_step = 16'd50; dead_time = 8'd0;
        start_run;
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (duty !== 16'(exp_d[k])) begin n_err++; $display("FAIL slew_duty p%0d: got %0d want %0d", k, duty, exp_d[k]); end
            n_cmp++; if (period_start !== 1'b1) begin n_err++; $display("FAIL slew_ps p%0d: got %b want 1", k, period_start); end
            if (k == 3) control_signal = 16'd0;
            repeat (1000) @(negedge clk);
        end
        enable = 1'b0;
    endtask

    task automatic test_deadtime;
        do_reset;
        period = 16'd20; control_signal = 16'd10; max_step = 16'd0; dead_time = 8'd3;
        start_run;
        for (int k = 0; k < 4; k++) begin
            int d = (k < 2) ? 10 : 2;
            for (int c = 0; c < 20; c++) begin
                logic eh, el;
                eh = (c < d) && (c >= 3);
                el = (c >= d + 3);
                n_cmp++; if (pwm_hi !== eh) begin n_err++; $display("FAIL dt_hi p%0d c%0d: got %b want %b", k, c, pwm_hi, eh); end
                n_cmp++; if (pwm_lo !== el) begin n_err++; $display("FAIL dt_lo p%0d c%0d: got %b want %b", k, c, pwm_lo, el); end
                if (k == 1 && c == 0) control_signal = 16'd2;
                @(negedge clk);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_edges;
        // period below the minimum runs as 2 cycles
        do_reset;
        period = 16'd0; control_signal = 16'd1; max_step = 16'd0; dead_time = 8'd0;
        start_run;
        for (int c = 0; c < 10; c++) begin
            logic ev;
            ev = (c % 2 == 0);
            n_cmp++; if (period_start !== ev) begin n_err++; $display("FAIL p0_ps c%0d: got %b want %b", c, period_start, ev); end
            n_cmp++; if (pwm_hi !== ev || pwm_lo !== !ev) begin n_err++; $display("FAIL p0_gates c%0d: got %b%b want %b%b", c, pwm_hi, pwm_lo, ev, !ev); end
            @(negedge clk);
        end

        // enable dropped mid-pulse
        do_reset;
        period = 16'd100; control_signal = 16'd50;
        start_run;
        repeat (10) @(negedge clk);
        n_cmp++; if (pwm_hi !== 1'b1) begin n_err++; $display("FAIL drop_pre_hi: got %b want 1", pwm_hi); end
        enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (pwm_hi !== 1'b0 || pwm_lo !== 1'b0) begin n_err++; $display("FAIL drop_gates: got %b%b want 00", pwm_hi, pwm_lo); end
        n_cmp++; if (duty !== 16'd50) begin n_err++; $display("FAIL drop_duty_held: got %0d want 50", duty); end
        repeat (5) @(negedge clk);
        n_cmp++; if ({pwm_hi, pwm_lo, period_start} !== 3'b000) begin n_err++; $display("FAIL drop_idle: got %b want 000", {pwm_hi, pwm_lo, period_start}); end

        // period change only lands after the current period completes
        do_reset;
        period = 16'd100; control_signal = 16'd30;
        start_run;
        for (int c = 0; c <= 150; c++) begin
            logic ev;
            ev = (c == 0 || c == 100 || c == 150);
            if (c == 10) period = 16'd50;
            n_cmp++; if (period_start !== ev) begin n_err++; $display("FAIL perchg_ps c%0d: got %b want %b", c, period_start, ev); end
            @(negedge clk);
        end
        enable = 1'b0;

        // asynchronous reset between clock edges
        do_reset;
        period = 16'd100; control_signal = 16'd50;
        start_run;
        repeat (5) @(negedge clk);
        n_cmp++; if (pwm_hi !== 1'b1 || duty !== 16'd50) begin n_err++; $display("FAIL arst_pre: got %b/%0d want 1/50", pwm_hi, duty); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({pwm_hi, pwm_lo, sat_flag, period_start} !== 4'b0000 || duty !== 16'd0) begin n_err++; $display("FAIL arst_clear: got %b/%0d want 0000/0", {pwm_hi, pwm_lo, sat_flag, period_start}, duty); end
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_inputs;
        int v;
        case ($urandom_range(0, 9))
            0:       control_signal = 16'h8000;
            1:       control_signal = 16'h7FFF;
            default: begin v = int'($urandom_range(0, 45)) - 5; control_signal = 16'(v); end
        endcase
        period   = 16'($urandom_range(0, 30));
        max_step = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
    endtask

    task automatic test_random;
        int duty_m = 0, per_m, tgt, diff, run_len = 0, nper, drop_c;
        bit sat_m = 0, raw, prev_raw = 0, first, eh, el;
        do_reset;
        for (int r = 0; r < 12; r++) begin
            dead_time = 8'($urandom_range(0, 6));
            nper = $urandom_range(2, 5);
            rand_inputs;
            enable = 1'b1;
            @(negedge clk);
            n_cmp++; if (pwm_hi !== 1'b0 || pwm_lo !== 1'b0) begin n_err++; $display("FAIL rnd_load_gates r%0d: got %b%b want 00", r, pwm_hi, pwm_lo); end
            @(negedge clk);
            first = 1;
            for (int k = 0; k < nper; k++) begin
                per_m = (period < 16'd2) ? 2 : int'(period);
                if ($signed(control_signal) < 0) begin tgt = 0; sat_m = 1; end
                else if (int'(control_signal) > per_m) begin tgt = per_m; sat_m = 1; end
                else begin tgt = int'(control_signal); sat_m = 0; end
                diff = tgt - duty_m;
                if (max_step != 0 && diff > int'(max_step)) duty_m += int'(max_step);
                else if (max_step != 0 && diff < -int'(max_step)) duty_m -= int'(max_step);
                else duty_m = tgt;
                drop_c = (k == nper - 1) ? int'($urandom_range(0, per_m - 1)) : -1;
                for (int c = 0; c < per_m; c++) begin
                    raw = (c < duty_m);
                    if (first || raw != prev_raw) run_len = 0;
                    else if (run_len < 255) run_len++;
                    first = 0; prev_raw = raw;
                    eh = raw && (run_len >= int'(dead_time));
                    el = !raw && (run_len >= int'(dead_time));
                    n_cmp++; if (pwm_hi !== eh || pwm_lo !== el) begin n_err++; $display("FAIL rnd_gates r%0d p%0d c%0d: got %b%b want %b%b", r, k, c, pwm_hi, pwm_lo, eh, el); end
                    n_cmp++; if (period_start !== (c == 0)) begin n_err++; $display("FAIL rnd_ps r%0d p%0d c%0d: got %b want %b", r, k, c, period_start, (c == 0)); end
                    if (c == 0) begin
                        n_cmp++; if (duty !== 16'(duty_m) || sat_flag !== sat_m) begin n_err++; $display("FAIL rnd_duty_sat r%0d p%0d: got %0d/%b want %0d/%b", r, k, duty, sat_flag, duty_m, sat_m); end
                        rand_inputs;
                    end
                    if (c == drop_c) begin
                        enable = 1'b0;
                        @(negedge clk);
                        n_cmp++; if ({pwm_hi, pwm_lo, period_start} !== 3'b000 || duty !== 16'(duty_m)) begin n_err++; $display("FAIL rnd_drop r%0d: got %b/%0d want 000/%0d", r, {pwm_hi, pwm_lo, period_start}, duty, duty_m); end
                        break;
                    end
                    @(negedge clk);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_basic;
        test_clamp;
        test_slew;
        test_deadtime;
        test_edges;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pid_pwm_driver.md
Name: pid_pwm_driver

Overview:
- Output stage directly downstream of the PID controller.
- Consumes the 16-bit signed control_signal and clamps it to the PWM period.
- Slew-rate-limits the duty change once per PWM period.
- Drives complementary high-side/low-side PWM gate signals with programmable dead time.

Parameters:
- DT_W, 8, width of dead_time input and dead-time counter.
- MIN_PERIOD, 2, smallest PWM period honoured; smaller period inputs are forced to this value.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  run PWM when high; idle when low.
- control_signal  input  16  PID output, signed two's complement.
- period  input  16  PWM period in clk cycles, unsigned.
- dead_time  input  DT_W  dead time in clk cycles, unsigned.
- max_step  input  16  maximum duty change per period, unsigned; 0 means unlimited.
- pwm_hi  output  1  high-side gate drive.
- pwm_lo  output  1  low-side gate drive.
- duty  output  16  duty currently applied, in cycles.
- sat_flag  output  1  the last sample was clamped, either low or high.
- period_start  output  1  one-cycle pulse in the first cycle of each period.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; cnt=0; duty=0; per_lat=MIN_PERIOD; dt_cnt=0.
  - pwm_hi=0, pwm_lo=0, sat_flag=0, period_start=0.
  - All outputs are registered.
- States:
  - IDLE:
    - cnt held at 0; duty held; pwm_hi=pwm_lo=0; period_start=0.
    - enable=1 -> LOAD.
  - LOAD (1 cycle):
    - Samples inputs, computes the new duty, latches per_lat.
    - Goes to RUN with cnt=0.
  - RUN:
    - cnt increments each cycle.
    - When cnt==per_lat-1: perform the LOAD computation this cycle; next cycle cnt=0.
    - period_start=1 in every cycle where cnt==0 in RUN.
    - enable=0 -> IDLE on the next cycle. Gates go to 0 immediately, on the next registered output.
- Sample/clamp (LOAD computation):
  - per_lat = max(period, MIN_PERIOD).
  - If control_signal is negative: target=0, sat_flag=1.
  - Else if control_signal > per_lat: target=per_lat, sat_flag=1.
  - Else: target=control_signal, sat_flag=0.
- Slew limit:
  - If max_step==0: duty=target.
  - Else: duty moves toward target by at most max_step.
    - Compute the difference in 17-bit arithmetic; no overflow or wrap.
    - Never overshoot target.
  - The new duty and per_lat take effect at the next cnt==0.
- Raw PWM: raw = (cnt < duty) in RUN; raw=0 in IDLE/LOAD.
  - duty=0: raw never high.
  - duty=per_lat: raw always high.
- Dead time:
  - dt_cnt resets to 0 on any raw transition.
  - Otherwise dt_cnt increments, saturating at all-ones.
  - pwm_hi = raw && (dt_cnt >= dead_time).
  - pwm_lo = !raw && (dt_cnt >= dead_time) && state==RUN.
  - pwm_hi and pwm_lo are never both 1, under any inputs.
  - dead_time=0: pwm_lo = !pwm_hi in RUN.
  - A pulse shorter than or equal to dead_time suppresses that gate for that phase.
  - Entering RUN counts as a raw transition, so dt_cnt starts at 0.
- Mid-operation changes:
  - period, max_step and control_signal are only sampled at LOAD.
  - dead_time is used live.
  - Reset mid-period returns to the reset values immediately.
- Latency:
  - A control_signal present at the cnt==per_lat-1 edge appears on duty at the next cnt==0, one cycle later.

Test Plan:
- Reset/idle: rst_n pulse, enable=0 -> pwm_hi=pwm_lo=0, duty=0, sat_flag=0, period_start never pulses.
- Basic duty: period=100, dead_time=0, max_step=0, control=25.
  - duty=25.
  - pwm_hi high 25 cycles, pwm_lo high 75 cycles per period.
  - period_start every 100 cycles.
- Clamp: period=100, control=-5 -> duty=0, sat_flag=1, pwm_lo constant 1. Then control=300 -> duty=100, sat_flag=1, pwm_hi constant 1.
- Slew: period=1000, max_step=50, duty 0, control=180 -> duty 50,100,150,180 over four consecutive periods. Then control=0 -> 130,80,30,0.
- Dead time: period=20, control=10, dead_time=3.
  - pwm_hi high for cnt 3..9.
  - pwm_lo high for cnt 13..19.
  - Never both high.
  - control=2 with dead_time=3 -> pwm_hi never asserts.
- Edge cases:
  - period=0 -> runs as period 2.
  - enable dropped mid-period -> gates 0 next cycle.
  - Period change from 100 to 50 mid-period takes effect only after the current period completes.
  - Async reset asserted mid-pulse clears all outputs without a clock edge.
